// File: rtl/control_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, ALU codes, FSM states
// and the instruction classes the field decoder reports.
package control_pkg;

    localparam int OP_NOP   = 0;
    localparam int OP_ADD   = 1;
    localparam int OP_SUB   = 2;
    localparam int OP_MOV   = 3;
    localparam int OP_LOAD  = 4;
    localparam int OP_STORE = 5;
    localparam int OP_ADDI  = 6;
    // Cast to the opcode width at the point of use, -1 becomes all ones for any OPC_W.
    localparam int OP_HALT  = -1;

    localparam int ALU_PASS = 0;
    localparam int ALU_ADD  = 1;
    localparam int ALU_SUB  = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_ALU,
        CLS_MOV,
        CLS_LOAD,
        CLS_STORE,
        CLS_HALT,
        CLS_ILL
    } cls_t;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Fetch/datapath-facing bundle of the control unit; the retired/illegal counters
// are present only when PERF_COUNTERS_EN is defined.
interface multicycle_control_unit_if #(
    parameter int INSTR_W = 32,
    parameter int REG_W   = 3,
    parameter int IMM_W   = 8,
    parameter int ALU_W   = 6
);
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               instr_ready;
    logic               mem_ready;
    logic [ALU_W-1:0]   alu_ctrl;
    logic               alu_src_imm;
    logic [REG_W-1:0]   r1;
    logic [REG_W-1:0]   r2;
    logic [REG_W-1:0]   rd;
    logic [IMM_W-1:0]   i1;
    logic [IMM_W-1:0]   i2;
    logic               rwe;
    logic               rwe2;
    logic               mwe;
    logic               mem_re;
    logic               busy;
    logic               illegal;
    logic               halted;
`ifdef PERF_COUNTERS_EN
    logic [31:0]        retired_cnt;
    logic [15:0]        illegal_cnt;
`endif

    modport master (
        output instr, instr_valid, mem_ready,
        input  instr_ready, alu_ctrl, alu_src_imm, r1, r2, rd, i1, i2,
        input  rwe, rwe2, mwe, mem_re, busy, illegal, halted
`ifdef PERF_COUNTERS_EN
        , input retired_cnt, illegal_cnt
`endif
    );

    modport slave (
        input  instr, instr_valid, mem_ready,
        output instr_ready, alu_ctrl, alu_src_imm, r1, r2, rd, i1, i2,
        output rwe, rwe2, mwe, mem_re, busy, illegal, halted
`ifdef PERF_COUNTERS_EN
        , output retired_cnt, illegal_cnt
`endif
    );

endinterface

// File: rtl/instr_field_decoder.sv
// Combinational field slicer and class/ALU lookup, applied to the latched
// instruction register so every output is a function of registered state only.
module instr_field_decoder
    import control_pkg::*;
#(
    parameter int INSTR_W = 32,
    parameter int OPC_W   = 6,
    parameter int REG_W   = 3,
    parameter int IMM_W   = 8,
    parameter int ALU_W   = 6
) (
    input  logic [INSTR_W-1:0] instr_i,
    output cls_t               cls_o,
    output logic [ALU_W-1:0]   alu_ctrl_o,
    output logic               alu_src_imm_o,
    output logic [REG_W-1:0]   rd_o,
    output logic [REG_W-1:0]   r1_o,
    output logic [REG_W-1:0]   r2_o,
    output logic [IMM_W-1:0]   i1_o,
    output logic [IMM_W-1:0]   i2_o
);
    logic [OPC_W-1:0] opcode;
    logic             unused_instr;

    assign opcode = instr_i[INSTR_W-1 -: OPC_W];
    assign rd_o   = instr_i[INSTR_W-OPC_W-1 -: REG_W];
    assign r1_o   = instr_i[INSTR_W-OPC_W-REG_W-1 -: REG_W];
    assign r2_o   = instr_i[INSTR_W-OPC_W-2*REG_W-1 -: REG_W];
    assign i1_o   = instr_i[2*IMM_W-1 : IMM_W];
    assign i2_o   = instr_i[IMM_W-1:0];

    // Bits between the register fields and i1 carry no meaning.
    assign unused_instr = ^instr_i;

    always_comb begin
        // NOTE: every output gets a default before the case so no path infers a latch.
        cls_o         = CLS_ILL;
        alu_ctrl_o    = ALU_W'(ALU_PASS);
        alu_src_imm_o = 1'b0;
        if (opcode == OPC_W'(OP_HALT)) begin
            cls_o = CLS_HALT;
        end else begin
            case (opcode)
                OPC_W'(OP_NOP):   cls_o = CLS_NOP;
                OPC_W'(OP_ADD):   begin cls_o = CLS_ALU;   alu_ctrl_o = ALU_W'(ALU_ADD); end
                OPC_W'(OP_SUB):   begin cls_o = CLS_ALU;   alu_ctrl_o = ALU_W'(ALU_SUB); end
                OPC_W'(OP_MOV):   cls_o = CLS_MOV;
                OPC_W'(OP_LOAD):  begin cls_o = CLS_LOAD;  alu_ctrl_o = ALU_W'(ALU_ADD); alu_src_imm_o = 1'b1; end
                OPC_W'(OP_STORE): begin cls_o = CLS_STORE; alu_ctrl_o = ALU_W'(ALU_ADD); alu_src_imm_o = 1'b1; end
                OPC_W'(OP_ADDI):  begin cls_o = CLS_ALU;   alu_ctrl_o = ALU_W'(ALU_ADD); alu_src_imm_o = 1'b1; end
                default:          cls_o = CLS_ILL;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle Moore control unit: accepts one instruction per handshake and sequences
// ALU write-back, MOV write and memory accesses. PERF_COUNTERS_EN adds retire/illegal counters.
module multicycle_control_unit
    import control_pkg::*;
#(
    parameter int INSTR_W = 32,
    parameter int OPC_W   = 6,
    parameter int REG_W   = 3,
    parameter int IMM_W   = 8,
    parameter int ALU_W   = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    multicycle_control_unit_if.slave  bus
);
    state_t             state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;

    cls_t               cls;
    logic [ALU_W-1:0]   dec_alu_ctrl;
    logic               dec_alu_src_imm;
    logic [REG_W-1:0]   dec_rd, dec_r1, dec_r2;
    logic [IMM_W-1:0]   dec_i1, dec_i2;

    logic instr_ready, accept;
    logic rwe, rwe2, mwe, mem_re, illegal;

    instr_field_decoder #(
        .INSTR_W (INSTR_W),
        .OPC_W   (OPC_W),
        .REG_W   (REG_W),
        .IMM_W   (IMM_W),
        .ALU_W   (ALU_W)
    ) u_decoder (
        .instr_i       (instr_q),
        .cls_o         (cls),
        .alu_ctrl_o    (dec_alu_ctrl),
        .alu_src_imm_o (dec_alu_src_imm),
        .rd_o          (dec_rd),
        .r1_o          (dec_r1),
        .r2_o          (dec_r2),
        .i1_o          (dec_i1),
        .i2_o          (dec_i2)
    );

    // Ready is held low for the whole reset cycle, not only after the reset edge.
    assign instr_ready = rst_n && (state_q == S_IDLE);
    assign accept      = bus.instr_valid && instr_ready;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q <= S_IDLE;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        rwe     = 1'b0;
        rwe2    = 1'b0;
        mwe     = 1'b0;
        mem_re  = 1'b0;
        illegal = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    instr_d = bus.instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (cls)
                    CLS_ILL:  begin illegal = 1'b1; state_d = S_IDLE; end
                    CLS_HALT: state_d = S_HALT;
                    CLS_NOP:  state_d = S_IDLE;
                    default:  state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (cls)
                    CLS_ALU:              begin rwe  = 1'b1; state_d = S_IDLE; end
                    CLS_MOV:              begin rwe2 = 1'b1; state_d = S_IDLE; end
                    CLS_LOAD, CLS_STORE:  state_d = S_MEM;
                    default:              state_d = S_IDLE;
                endcase
            end
            S_MEM: begin
                if (cls == CLS_STORE) mwe = 1'b1;
                else                  mem_re = 1'b1;
                if (bus.mem_ready) state_d = (cls == CLS_STORE) ? S_IDLE : S_WB;
            end
            S_WB: begin
                rwe     = 1'b1;
                state_d = S_IDLE;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.instr_ready = instr_ready;
    assign bus.alu_ctrl    = dec_alu_ctrl;
    assign bus.alu_src_imm = dec_alu_src_imm;
    assign bus.r1          = dec_r1;
    assign bus.r2          = dec_r2;
    assign bus.rd          = dec_rd;
    assign bus.i1          = dec_i1;
    assign bus.i2          = dec_i2;
    assign bus.rwe         = rwe;
    assign bus.rwe2        = rwe2;
    assign bus.mwe         = mwe;
    assign bus.mem_re      = mem_re;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.illegal     = illegal;
    assign bus.halted      = (state_q == S_HALT);

`ifdef PERF_COUNTERS_EN
    logic [31:0] retired_cnt_q, retired_cnt_d;
    logic [15:0] illegal_cnt_q, illegal_cnt_d;
    logic        retire;

    // A STORE retires on its completing memory cycle, a NOP on leaving decode.
    assign retire = rwe || rwe2 || (mwe && bus.mem_ready)
                 || (state_q == S_DECODE && cls == CLS_NOP);

    assign retired_cnt_d = retire  ? retired_cnt_q + 32'd1 : retired_cnt_q;
    assign illegal_cnt_d = illegal ? illegal_cnt_q + 16'd1 : illegal_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retired_cnt_q <= '0;
            illegal_cnt_q <= '0;
        end else begin
            retired_cnt_q <= retired_cnt_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign bus.retired_cnt = retired_cnt_q;
    assign bus.illegal_cnt = illegal_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench: stimulus pushes expected enable/illegal events into a scoreboard,
// a negedge monitor pops and compares whenever the DUT raises one.
module tb_multicycle_control_unit;

    typedef struct {
        int         cyc;
        logic [4:0] en;     // {rwe, rwe2, mwe, mem_re, illegal}
        logic [2:0] rd;
        logic [5:0] alu;
        logic [7:0] i1;
        logic [7:0] i2;
    } exp_t;

    localparam logic [4:0] EN_RWE  = 5'b10000;
    localparam logic [4:0] EN_RWE2 = 5'b01000;
    localparam logic [4:0] EN_MWE  = 5'b00100;
    localparam logic [4:0] EN_MRE  = 5'b00010;
    localparam logic [4:0] EN_ILL  = 5'b00001;

    localparam logic [31:0] I_ADD   = 32'h0694_0000; // rd=5 r1=1 r2=2
    localparam logic [31:0] I_MOV   = 32'h0C00_ABCD; // i1=AB i2=CD
    localparam logic [31:0] I_STORE = 32'h1580_0010; // rd=3 i2=10
    localparam logic [31:0] I_LOAD  = 32'h1300_0022; // rd=6 i2=22
    localparam logic [31:0] I_NOP   = 32'h0000_0000;
    localparam logic [31:0] I_ILL   = 32'hA800_0000; // opcode 0x2A
    localparam logic [31:0] I_HALT  = 32'hFC00_0000;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];

    multicycle_control_unit_if #(.INSTR_W(32), .REG_W(3), .IMM_W(8), .ALU_W(6)) bus ();

    multicycle_control_unit #(
        .INSTR_W (32),
        .OPC_W   (6),
        .REG_W   (3),
        .IMM_W   (8),
        .ALU_W   (6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [4:0] en, input logic [2:0] rd,
                        input logic [5:0] alu, input logic [7:0] i1, input logic [7:0] i2);
        exp_t e;
        e.cyc = c; e.en = en; e.rd = rd; e.alu = alu; e.i1 = i1; e.i2 = i2;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns with the bench 1 time unit into the decode cycle (cycle +1 after accept).
    task automatic send(input logic [31:0] w, output int acc);
        int n = 0;
        while (!bus.instr_ready && n < 40) begin
            step(1);
            n++;
        end
        check("ready_before_send", bus.instr_ready, 1);
        bus.instr       = w;
        bus.instr_valid = 1'b1;
        step(1);
        acc             = cyc;
        bus.instr_valid = 1'b0;
        bus.instr       = '1;
    endtask

    // Scoreboard monitor: an event observed in cycle +k after accept carries cyc = acc + k - 1.
    always @(negedge clk) begin
        logic [4:0] en;
        en = {bus.rwe, bus.rwe2, bus.mwe, bus.mem_re, bus.illegal};
        if (en != 5'b0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", 64'(en), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("event_cycle", 64'(cyc), 64'(e.cyc));
                check("event_enables", 64'(en), 64'(e.en));
                check("event_fields", {39'd0, bus.rd, bus.alu_ctrl, bus.i1, bus.i2},
                      {39'd0, e.rd, e.alu, e.i1, e.i2});
            end
        end
    end

    initial begin
        int acc;
        rst_n           = 1'b0;
        bus.instr_valid = 1'b0;
        bus.mem_ready   = 1'b0;
        bus.instr       = '0;
        step(3);
        check("rst_ready", bus.instr_ready, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_halted", bus.halted, 0);
        check("rst_fields", {bus.rd, bus.r1, bus.r2, bus.alu_ctrl, bus.i1, bus.i2, bus.alu_src_imm}, 0);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", bus.instr_ready, 1);

        // ADD: rwe at +2, ready again at +3
        send(I_ADD, acc);
        push(acc + 1, EN_RWE, 3'd5, 6'd1, 8'h00, 8'h00);
        check("add_rd", bus.rd, 5);
        check("add_r1", bus.r1, 1);
        check("add_r2", bus.r2, 2);
        check("add_alu", bus.alu_ctrl, 6'b000001);
        check("add_src_imm", bus.alu_src_imm, 0);
        check("add_busy", bus.busy, 1);
        step(1);
        check("add_ready_exec", bus.instr_ready, 0);
        step(1);
        check("add_ready_plus3", bus.instr_ready, 1);

        // MOV: single rwe2 pulse with immediates
        send(I_MOV, acc);
        push(acc + 1, EN_RWE2, 3'd0, 6'd0, 8'hAB, 8'hCD);
        check("mov_src_imm", bus.alu_src_imm, 0);
        step(2);
        check("mov_ready", bus.instr_ready, 1);

        // STORE, mem_ready low for the first three S_MEM cycles
        send(I_STORE, acc);
        for (int k = 2; k <= 5; k++) push(acc + k, EN_MWE, 3'd3, 6'd1, 8'h00, 8'h10);
        check("store_src_imm", bus.alu_src_imm, 1);
        step(5);
        bus.mem_ready = 1'b1;
        step(1);
        bus.mem_ready = 1'b0;
        check("store_mwe_dropped", bus.mwe, 0);
        check("store_ready", bus.instr_ready, 1);

        // LOAD, same stall, then one write-back cycle
        send(I_LOAD, acc);
        for (int k = 2; k <= 5; k++) push(acc + k, EN_MRE, 3'd6, 6'd1, 8'h00, 8'h22);
        push(acc + 6, EN_RWE, 3'd6, 6'd1, 8'h00, 8'h22);
        step(5);
        bus.mem_ready = 1'b1;
        step(1);
        bus.mem_ready = 1'b0;
        check("load_ready_in_wb", bus.instr_ready, 0);
        step(1);
        check("load_ready", bus.instr_ready, 1);

        // NOP returns to idle at +2 without any enable
        send(I_NOP, acc);
        step(1);
        check("nop_ready", bus.instr_ready, 1);
        check("nop_busy", bus.busy, 0);

        // Illegal opcode 0x2A
        send(I_ILL, acc);
        push(acc, EN_ILL, 3'd0, 6'd0, 8'h00, 8'h00);
        step(1);
        check("ill_ready", bus.instr_ready, 1);
`ifdef PERF_COUNTERS_EN
        check("illegal_cnt", bus.illegal_cnt, 1);
        check("retired_cnt", bus.retired_cnt, 5);
`endif

        // Reset during LOAD's second S_MEM cycle
        send(I_LOAD, acc);
        push(acc + 2, EN_MRE, 3'd6, 6'd1, 8'h00, 8'h22);
        push(acc + 3, EN_MRE, 3'd6, 6'd1, 8'h00, 8'h22);
        step(3);
        rst_n = 1'b0;
        step(1);
        check("abort_mem_re", bus.mem_re, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_ready_in_rst", bus.instr_ready, 0);
        rst_n = 1'b1;
`ifdef PERF_COUNTERS_EN
        check("rst_cnt_clear", {bus.retired_cnt, bus.illegal_cnt}, 0);
`endif
        step(10);
        check("abort_ready", bus.instr_ready, 1);

        // HALT is absorbing until reset
        send(I_HALT, acc);
        step(1);
        check("halted", bus.halted, 1);
        bus.instr       = I_ADD;
        bus.instr_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            check("halt_ready", bus.instr_ready, 0);
            step(1);
        end
        bus.instr_valid = 1'b0;
        check("still_halted", bus.halted, 1);
        rst_n = 1'b0;
        step(1);
        check("halt_rst_halted", bus.halted, 0);
        rst_n = 1'b1;
        #1;
        check("halt_rst_ready", bus.instr_ready, 1);

        step(3);
        check("scoreboard_empty", 64'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
